// File: rtl/sync_filter_pkg.sv
// Shared types and limits for the synchronizer / glitch-filter bank.
package sync_filter_pkg;

  // Fewer than two flops gives no metastability settling time.
  localparam int unsigned MIN_SYNC_STAGES = 2;

  // Registered per-channel outputs.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } ch_status_t;

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: synchronizer chain, debounce counter and registered edge pulses.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              async_in,
  input  logic [FILT_W-1:0] filt_len,
  output ch_status_t        status,
  output logic              upd
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_filter_ch: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
  end

  (* preserve, dont_replicate *) logic [SYNC_STAGES-1:0] sync_ff;

  logic              s;
  logic              level;
  logic              rise;
  logic              fall;
  logic [FILT_W-1:0] cnt;
  logic [FILT_W-1:0] cnt_nxt;
  logic [FILT_W-1:0] thr;
  logic [FILT_W:0]   cnt_inc;
  logic              mismatch;

  assign s = sync_ff[SYNC_STAGES-1];

  // Plain shift chain: nothing between the synchronizer flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_ff <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_in};
    end
  end

  // Debounce decision: accept s once it has disagreed with level for thr samples.
  // The compare is one bit wider so cnt at all-ones still reaches any threshold.
  always_comb begin
    thr      = (filt_len == '0) ? FILT_W'(1) : filt_len;
    cnt_inc  = {1'b0, cnt} + (FILT_W+1)'(1);
    mismatch = s ^ level;
    upd      = mismatch && (cnt_inc >= {1'b0, thr});
    if (!mismatch || upd) begin
      cnt_nxt = '0;
    end else if (cnt == '1) begin
      cnt_nxt = cnt;
    end else begin
      cnt_nxt = cnt_inc[FILT_W-1:0];
    end
  end

  // Filtered level, counter and edge pulses, all updated together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= RESET_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      rise  <= upd & s;
      fall  <= upd & ~s;
      if (upd) begin
        level <= s;
      end
    end
  end

  assign status = '{level: level, rise: rise, fall: fall};

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel input conditioner: per-channel sync + debounce + edges, plus sticky W1C event flags.
module sync_filter_bank
  import sync_filter_pkg::*;
#(
  parameter int unsigned           NUM_CH      = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           FILT_W      = 4,
  parameter logic [NUM_CH-1:0]     RESET_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] async_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [NUM_CH-1:0] evt_clr,
  output logic [NUM_CH-1:0] dout,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] evt_flag,
  output logic              evt_any
);

  ch_status_t        status [NUM_CH];
  logic [NUM_CH-1:0] upd;
  logic [NUM_CH-1:0] evt_flag_nxt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .RESET_VAL   (RESET_VAL[c])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (async_in[c]),
      .filt_len (filt_len),
      .status   (status[c]),
      .upd      (upd[c])
    );
    assign dout[c]       = status[c].level;
    assign rise_pulse[c] = status[c].rise;
    assign fall_pulse[c] = status[c].fall;
  end

  // Set has priority over a simultaneous clear.
  always_comb begin
    evt_flag_nxt = (evt_flag & ~evt_clr) | upd;
  end

  // evt_any comes from the next-state flags so it lines up with evt_flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_flag <= '0;
      evt_any  <= 1'b0;
    end else begin
      evt_flag <= evt_flag_nxt;
      evt_any  <= |evt_flag_nxt;
    end
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Self-checking bench for sync_filter_bank: directed scenarios plus randomized run against a behavioural model.
module tb_sync_filter_bank;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] async_in = 8'h00;
  logic [7:0] evt_clr = 8'h00;
  logic [3:0] filt_len = 4'h0;

  logic [7:0] dout, rise_pulse, fall_pulse, evt_flag;
  logic       evt_any;
  logic [7:0] dout3, rise3, fall3, flag3;
  logic       any3;
  logic [7:0] dout4, rise4, fall4, flag4;
  logic       any4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_filter_bank #(.NUM_CH(8), .SYNC_STAGES(2), .FILT_W(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .filt_len(filt_len), .evt_clr(evt_clr),
    .dout(dout), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .evt_flag(evt_flag), .evt_any(evt_any));

  sync_filter_bank #(.NUM_CH(8), .SYNC_STAGES(3), .FILT_W(4), .RESET_VAL(8'h00)) dut3 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .filt_len(filt_len), .evt_clr(evt_clr),
    .dout(dout3), .rise_pulse(rise3), .fall_pulse(fall3), .evt_flag(flag3), .evt_any(any3));

  sync_filter_bank #(.NUM_CH(8), .SYNC_STAGES(4), .FILT_W(4), .RESET_VAL(8'h00)) dut4 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .filt_len(filt_len), .evt_clr(evt_clr),
    .dout(dout4), .rise_pulse(rise4), .fall_pulse(fall4), .evt_flag(flag4), .evt_any(any4));

  // Reference model of the main (2-stage) instance.
  logic [7:0] m_hist [$];   // m_hist[0] is the newest sample taken from the pins
  int         m_run [8];    // consecutive samples disagreeing with the filtered level
  logic [7:0] m_dout, m_rise, m_fall, m_flag;
  logic       m_any;

  task automatic model_step();
    logic [7:0] s, upd;
    int thr;
    if (!rst_n) begin
      m_hist = {};
      for (int i = 0; i < S; i++) m_hist.push_back(8'h00);
      for (int c = 0; c < 8; c++) m_run[c] = 0;
      m_dout = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_flag = 8'h00; m_any = 1'b0;
    end else begin
      s   = m_hist[S-1];
      thr = (filt_len == 4'h0) ? 1 : int'(filt_len);
      upd = 8'h00;
      for (int c = 0; c < 8; c++) begin
        if (s[c] != m_dout[c]) begin
          if (m_run[c] + 1 >= thr) begin
            upd[c]   = 1'b1;
            m_run[c] = 0;
          end else begin
            m_run[c] = (m_run[c] < 15) ? m_run[c] + 1 : 15;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_rise = upd & s;
      m_fall = upd & ~s;
      m_dout = (m_dout & ~upd) | (s & upd);
      m_flag = (m_flag & ~evt_clr) | upd;
      m_any  = |m_flag;
      m_hist.push_front(async_in);
      void'(m_hist.pop_back());
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Bring every channel of all instances to a known level with flags cleared.
  task automatic settle(input logic [7:0] val);
    rst_n = 1'b1; async_in = val; filt_len = 4'h0; evt_clr = 8'h00;
    repeat (6) tick();
    evt_clr = 8'hFF;
    tick();
    evt_clr = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] exp_d, exp_r, exp_f;
    rst_n = 1'b0; async_in = 8'hFF; filt_len = 4'h0; evt_clr = 8'h00;
    repeat (3) tick();
    n_checks++;
    if ({dout, rise_pulse, fall_pulse, evt_flag, evt_any} !== 33'h0)
      $display("FAIL reset_state: got dout=%h rise=%h fall=%h flag=%h any=%b, expected all 0",
               dout, rise_pulse, fall_pulse, evt_flag, evt_any);
    else n_pass++;
    rst_n = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      exp_d = (t >= 3) ? 8'hFF : 8'h00;
      exp_r = (t == 3) ? 8'hFF : 8'h00;
      exp_f = exp_d;
      n_checks++;
      if ({dout, rise_pulse, evt_flag} !== {exp_d, exp_r, exp_f})
        $display("FAIL reset_release_t%0d: got dout=%h rise=%h flag=%h, expected dout=%h rise=%h flag=%h",
                 t, dout, rise_pulse, evt_flag, exp_d, exp_r, exp_f);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic ok;
    settle(8'h00);
    filt_len = 4'd4;
    async_in = 8'h01;
    repeat (3) tick();
    async_in = 8'h00;
    ok = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (dout[0] !== 1'b0 || rise_pulse[0] !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (!ok) $display("FAIL glitch_reject: got dout[0]=%b rise[0]=%b, expected 0 throughout", dout[0], rise_pulse[0]);
    else n_pass++;
    async_in = 8'h01;
    for (int t = 1; t <= 6; t++) begin
      tick();
      n_checks++;
      if ({dout[0], rise_pulse[0]} !== {2{t == 6}})
        $display("FAIL glitch_accept_t%0d: got dout[0]=%b rise[0]=%b, expected %b", t, dout[0], rise_pulse[0], t == 6);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    int first [3];
    int edge_at [3];
    logic [2:0] nw, edg;
    settle(8'h00);
    for (int dir = 1; dir >= 0; dir--) begin
      async_in[3] = dir[0];
      first = '{0, 0, 0};
      edge_at = '{0, 0, 0};
      for (int t = 1; t <= 8; t++) begin
        tick();
        nw  = {dout4[3], dout3[3], dout[3]};
        edg = dir[0] ? {rise4[3], rise3[3], rise_pulse[3]} : {fall4[3], fall3[3], fall_pulse[3]};
        for (int d = 0; d < 3; d++) begin
          if (first[d] == 0 && nw[d] == dir[0]) first[d] = t;
          if (edge_at[d] == 0 && edg[d]) edge_at[d] = t;
        end
      end
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (first[d] != d + 3 || edge_at[d] != d + 3)
          $display("FAIL latency_stages%0d_dir%0d: got change at %0d pulse at %0d, expected both at %0d",
                   d + 2, dir, first[d], edge_at[d], d + 3);
        else n_pass++;
      end
    end
    n_checks++;
    if ({flag4[3], any4, flag3[3], any3, evt_flag[3], evt_any} !== 6'h3F)
      $display("FAIL latency_flags: got %b, expected 111111",
               {flag4[3], any4, flag3[3], any3, evt_flag[3], evt_any});
    else n_pass++;
  endtask

  task automatic test_flags();
    settle(8'h00);
    async_in = 8'h20;
    tick();
    tick();
    evt_clr = 8'h20;
    tick();
    n_checks++;
    if ({rise_pulse, evt_flag, evt_any} !== {8'h20, 8'h20, 1'b1})
      $display("FAIL flag_set_wins: got rise=%h flag=%h any=%b, expected rise=20 flag=20 any=1",
               rise_pulse, evt_flag, evt_any);
    else n_pass++;
    tick();
    n_checks++;
    if ({rise_pulse, evt_flag, evt_any} !== 17'h0)
      $display("FAIL flag_clear: got rise=%h flag=%h any=%b, expected all 0", rise_pulse, evt_flag, evt_any);
    else n_pass++;
    evt_clr = 8'h00;
  endtask

  task automatic test_reset_mid();
    settle(8'h00);
    filt_len = 4'd8;
    async_in = 8'h04;
    repeat (7) tick();
    n_checks++;
    if (dout[2] !== 1'b0) $display("FAIL midreset_pre: got dout[2]=%b, expected 0", dout[2]);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({dout, evt_flag} !== 16'h0) $display("FAIL midreset_state: got dout=%h flag=%h, expected 0", dout, evt_flag);
    else n_pass++;
    for (int t = 1; t <= 10; t++) begin
      tick();
      n_checks++;
      if ({dout[2], rise_pulse[2]} !== {2{t == 10}})
        $display("FAIL midreset_t%0d: got dout[2]=%b rise[2]=%b, expected %b", t, dout[2], rise_pulse[2], t == 10);
      else n_pass++;
    end
  endtask

  task automatic test_threshold();
    int rises;
    settle(8'h00);
    filt_len = 4'd10;
    async_in = 8'h40;
    repeat (8) tick();
    n_checks++;
    if (dout[6] !== 1'b0) $display("FAIL thresh_pre: got dout[6]=%b, expected 0", dout[6]);
    else n_pass++;
    filt_len = 4'd2;
    tick();
    n_checks++;
    if ({dout[6], rise_pulse[6]} !== 2'b11)
      $display("FAIL thresh_lowered: got dout[6]=%b rise[6]=%b, expected 1 1", dout[6], rise_pulse[6]);
    else n_pass++;
    rises = 0;
    repeat (4) begin
      tick();
      if (rise_pulse[6]) rises++;
    end
    n_checks++;
    if (rises != 0 || dout[6] !== 1'b1)
      $display("FAIL thresh_single_pulse: got %0d extra rises dout[6]=%b, expected 0 and 1", rises, dout[6]);
    else n_pass++;
  endtask

  task automatic test_random();
    settle(8'h00);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 8; c++)
        if ($urandom_range(0, 5) == 0) async_in[c] = ~async_in[c];
      if ($urandom_range(0, 39) == 0) filt_len = 4'($urandom_range(0, 5));
      evt_clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rst_n   = ($urandom_range(0, 149) != 0);
      tick();
      n_checks++;
      if ({dout, rise_pulse, fall_pulse, evt_flag, evt_any} !== {m_dout, m_rise, m_fall, m_flag, m_any})
        $display("FAIL random_cycle%0d: got dout=%h rise=%h fall=%h flag=%h any=%b, expected dout=%h rise=%h fall=%h flag=%h any=%b",
                 i, dout, rise_pulse, fall_pulse, evt_flag, evt_any, m_dout, m_rise, m_fall, m_flag, m_any);
      else n_pass++;
    end
    rst_n = 1'b1;
    evt_clr = 8'h00;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_latency();
    test_flags();
    test_reset_mid();
    test_threshold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
